// File: rtl/conv_pkg.sv
// conv_pkg: shared sizing constants and FSM state type for the 3x3 window controller.
package conv_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned IMG_W  = 640;
    localparam int unsigned NUM_LB = 4;
    localparam int unsigned WIN_W  = 9 * PIX_W;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

endpackage

// File: rtl/win_row_buf.sv
// win_row_buf: one image-row RAM with a single write port and a 3-pixel read port.
// Read columns are addr, addr+1, addr+2; columns past the row end replicate the last pixel.
module win_row_buf #(
    parameter int unsigned IMG_W = conv_pkg::IMG_W,
    parameter int unsigned PIX_W = conv_pkg::PIX_W,
    parameter int unsigned AW    = $clog2(IMG_W)
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic [AW-1:0]        rd_addr,
    output logic [3*PIX_W-1:0]   rd_data
);

    localparam logic [AW:0]   LAST_EXT = (AW+1)'(IMG_W - 1);
    localparam logic [AW-1:0] LAST     = AW'(IMG_W - 1);

    logic [PIX_W-1:0] mem [IMG_W];
    logic [AW:0]      nxt1;
    logic [AW:0]      nxt2;
    logic [AW-1:0]    addr1;
    logic [AW-1:0]    addr2;

    // Write port; RAM contents are never cleared, reset only discards them logically
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Neighbour columns computed one bit wider so the clamp sees the overrun
    always_comb begin
        nxt1    = {1'b0, rd_addr} + (AW+1)'(1);
        nxt2    = {1'b0, rd_addr} + (AW+1)'(2);
        addr1   = (nxt1 > LAST_EXT) ? LAST : nxt1[AW-1:0];
        addr2   = (nxt2 > LAST_EXT) ? LAST : nxt2[AW-1:0];
        rd_data = {mem[rd_addr], mem[addr1], mem[addr2]};
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: stores the pixel stream in 4 rotating row buffers and emits
// one 3x3 window per cycle from the three oldest complete rows.
// Optional macro WIN_OVERFLOW_FLAG_EN adds the sticky o_overflow output.
module conv_window_ctrl #(
    parameter int unsigned IMG_W = conv_pkg::IMG_W,
    parameter int unsigned PIX_W = conv_pkg::PIX_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     i_pix,
    input  logic                 i_pix_valid,
    output logic [9*PIX_W-1:0]   o_win,
    output logic                 o_win_valid,
    output logic                 o_line_done
`ifdef WIN_OVERFLOW_FLAG_EN
    ,
    output logic                 o_overflow
`endif
);

    import conv_pkg::*;

    localparam int unsigned    AW       = $clog2(IMG_W);
    localparam int unsigned    FW       = $clog2(NUM_LB * IMG_W) + 1;
    localparam logic [FW-1:0]  FILL_MAX = FW'(NUM_LB * IMG_W);
    localparam logic [FW-1:0]  FILL_RD  = FW'(3 * IMG_W);
    localparam logic [AW-1:0]  COL_LAST = AW'(IMG_W - 1);

    logic [AW-1:0]       wr_col;
    logic [1:0]          wr_sel;
    logic [AW-1:0]       rd_col;
    logic [1:0]          rd_sel;
    logic [FW-1:0]       fill;
    state_t              state;

    logic                wr_acc;
    logic                rd_cyc;
    logic [1:0]          sel1;
    logic [1:0]          sel2;
    logic [9*PIX_W-1:0]  win_next;
    logic [3*PIX_W-1:0]  row_data [NUM_LB];

    assign wr_acc = i_pix_valid && (fill < FILL_MAX);
    assign rd_cyc = (state == READ);

    for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
        win_row_buf #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W)
        ) u_buf (
            .clk     (clk),
            .wr_en   (wr_acc && (wr_sel == 2'(g))),
            .wr_addr (wr_col),
            .wr_data (i_pix),
            .rd_addr (rd_col),
            .rd_data (row_data[g])
        );
    end

    // Write pointer: column within the row, then rotate to the next buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_col <= '0;
            wr_sel <= '0;
        end else if (wr_acc) begin
            if (wr_col == COL_LAST) begin
                wr_col <= '0;
                wr_sel <= wr_sel + 2'd1;
            end else begin
                wr_col <= wr_col + AW'(1);
            end
        end
    end

    // Occupancy: +1 per accepted write, -1 per read cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else begin
            case ({wr_acc, rd_cyc})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Window assembly: oldest row first, rotating with rd_sel
    always_comb begin
        sel1     = rd_sel + 2'd1;
        sel2     = rd_sel + 2'd2;
        win_next = {row_data[rd_sel], row_data[sel1], row_data[sel2]};
    end

    // Read FSM with registered window outputs; each row ends in at least one IDLE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rd_col      <= '0;
            rd_sel      <= '0;
            o_win       <= '0;
            o_win_valid <= 1'b0;
            o_line_done <= 1'b0;
        end else begin
            o_win_valid <= 1'b0;
            o_line_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fill >= FILL_RD) begin
                        state <= READ;
                    end
                end
                READ: begin
                    o_win       <= win_next;
                    o_win_valid <= 1'b1;
                    if (rd_col == COL_LAST) begin
                        rd_col      <= '0;
                        rd_sel      <= rd_sel + 2'd1;
                        o_line_done <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        rd_col <= rd_col + AW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WIN_OVERFLOW_FLAG_EN
    // Sticky flag: set by the first dropped write, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_overflow <= 1'b0;
        end else if (i_pix_valid && !wr_acc) begin
            o_overflow <= 1'b1;
        end
    end
`else
    // Dropped writes are silent in this build
`endif

endmodule
